// File: rtl/tb_mem_arbiter_if.sv
// tb_mem_arbiter_if: requester, memory and status signals of the two-port test-memory arbiter
interface tb_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              r0_valid;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_sz;
    logic              r0_we;
    logic              r0_grant;
    logic              r0_done;
    logic [DATA_W-1:0] r0_rdata;
    logic              r1_valid;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_sz;
    logic              r1_we;
    logic              r1_grant;
    logic              r1_done;
    logic [DATA_W-1:0] r1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_sz;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  r0_valid, r0_addr, r0_wdata, r0_sz, r0_we,
        input  r1_valid, r1_addr, r1_wdata, r1_sz, r1_we,
        input  mem_rdata,
        output r0_grant, r0_done, r0_rdata,
        output r1_grant, r1_done, r1_rdata,
        output mem_addr, mem_wdata, mem_sz, mem_we, busy
    );

    modport master (
        output r0_valid, r0_addr, r0_wdata, r0_sz, r0_we,
        output r1_valid, r1_addr, r1_wdata, r1_sz, r1_we,
        output mem_rdata,
        input  r0_grant, r0_done, r0_rdata,
        input  r1_grant, r1_done, r1_rdata,
        input  mem_addr, mem_wdata, mem_sz, mem_we, busy
    );
endinterface

// File: rtl/tb_mem_arbiter.sv
// tb_mem_arbiter: shares one phase-unknown synchronous memory between a fetch port and a data port
module tb_mem_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int MEM_HOLD       = 2,
    parameter int FIXED_PRIORITY = 0
) (
    input logic              clk,
    input logic              reset,
    tb_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, SETTLE} state_t;

    localparam logic [3:0] HOLD_INIT = 4'(MEM_HOLD - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              sz_q, sz_d;
    logic              we_q, we_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        done_q, done_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [1:0]        valid;
    logic              sel;

    assign valid = {bus.r1_valid, bus.r0_valid};
    assign sel   = &valid ? (FIXED_PRIORITY != 0 ? 1'b0 : ~last_q) : valid[1];

    // Next state: latch the winner's command in IDLE, hold it MEM_HOLD cycles, then one settle cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        win_d    = win_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sz_d     = sz_q;
        we_d     = we_q;
        grant_d  = 2'b00;
        done_d   = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (|valid) begin
                    state_d = ACCESS;
                    cnt_d   = HOLD_INIT;
                    win_d   = sel;
                    last_d  = sel;
                    addr_d  = sel ? bus.r1_addr  : bus.r0_addr;
                    wdata_d = sel ? bus.r1_wdata : bus.r0_wdata;
                    sz_d    = sel ? bus.r1_sz    : bus.r0_sz;
                    we_d    = sel ? bus.r1_we    : bus.r0_we;
                    grant_d = sel ? 2'b10 : 2'b01;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) state_d = SETTLE;
                else cnt_d = cnt_q - 4'd1;
            end
            SETTLE: begin
                state_d  = IDLE;
                done_d   = win_q ? 2'b10 : 2'b01;
                rdata0_d = (!we_q && !win_q) ? bus.mem_rdata : rdata0_q;
                rdata1_d = (!we_q &&  win_q) ? bus.mem_rdata : rdata1_q;
            end
            default: state_d = IDLE;
        endcase
        mem_we_d = (state_d == ACCESS) && we_d;
        busy_d   = state_d != IDLE;
    end

    // Registered state and outputs; reset abandons any in-flight access
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sz_q     <= 1'b0;
            we_q     <= 1'b0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
            grant_q  <= 2'b00;
            done_q   <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            win_q    <= win_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sz_q     <= sz_d;
            we_q     <= we_d;
            mem_we_q <= mem_we_d;
            busy_q   <= busy_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_sz    = sz_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.busy      = busy_q;
    assign bus.r0_grant  = grant_q[0];
    assign bus.r1_grant  = grant_q[1];
    assign bus.r0_done   = done_q[0];
    assign bus.r1_done   = done_q[1];
    assign bus.r0_rdata  = rdata0_q;
    assign bus.r1_rdata  = rdata1_q;
endmodule

// File: tb/tb_tb_mem_arbiter.sv
// tb_tb_mem_arbiter: round-robin and fixed-priority arbiters against a transaction-level model
module tb_tb_mem_arbiter;
    localparam int H = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        v  [2][2];
    logic [15:0] a  [2][2];
    logic [15:0] wd [2][2];
    logic        s  [2][2];
    logic        w  [2][2];
    wire         g  [2][2];
    wire         dn [2][2];
    wire  [15:0] rd [2][2];
    wire  [15:0] maddr [2];
    wire  [15:0] mwd [2];
    wire         msz [2];
    wire         mwe [2];
    wire         bsy [2];
    logic [15:0] mrd [2];

    for (genvar d = 0; d < 2; d++) begin : g_inst
        tb_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
        assign bus.r0_valid  = v[d][0];
        assign bus.r0_addr   = a[d][0];
        assign bus.r0_wdata  = wd[d][0];
        assign bus.r0_sz     = s[d][0];
        assign bus.r0_we     = w[d][0];
        assign bus.r1_valid  = v[d][1];
        assign bus.r1_addr   = a[d][1];
        assign bus.r1_wdata  = wd[d][1];
        assign bus.r1_sz     = s[d][1];
        assign bus.r1_we     = w[d][1];
        assign bus.mem_rdata = mrd[d];
        assign g[d][0]  = bus.r0_grant;
        assign g[d][1]  = bus.r1_grant;
        assign dn[d][0] = bus.r0_done;
        assign dn[d][1] = bus.r1_done;
        assign rd[d][0] = bus.r0_rdata;
        assign rd[d][1] = bus.r1_rdata;
        assign maddr[d] = bus.mem_addr;
        assign mwd[d]   = bus.mem_wdata;
        assign msz[d]   = bus.mem_sz;
        assign mwe[d]   = bus.mem_we;
        assign bsy[d]   = bus.busy;
        tb_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_HOLD(H), .FIXED_PRIORITY(d)) dut (
            .clk(clk),
            .reset(reset),
            .bus(bus.slave)
        );
    end

    function automatic logic [7:0] init_byte(int i);
        return i == 16 ? 8'h12 : i == 17 ? 8'h34 : i < 6 ? 8'((i + 1) * 17) : 8'h00;
    endfunction

    logic       preload = 1'b0;
    logic       phase = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] mem [2][256];
    logic       tog [2];

    // Single-port memory that only services every other edge, phase chosen at preload
    always @(posedge clk) begin : memory
        logic [7:0] i0, i1;
        for (int d = 0; d < 2; d++) begin
            i0 = maddr[d][7:0];
            i1 = i0 + 8'd1;
            if (preload) begin
                for (int i = 0; i < 256; i++) mem[d][i] <= init_byte(i);
                tog[d] <= phase;
                mrd[d] <= 16'h0000;
            end else begin
                tog[d] <= ~tog[d];
                if (tog[d]) begin
                    if (mwe[d] && msz[d]) begin
                        mem[d][i0] <= mwd[d][15:8];
                        mem[d][i1] <= mwd[d][7:0];
                    end else if (mwe[d]) begin
                        mem[d][i0] <= mwd[d][7:0];
                    end
                    mrd[d] <= msz[d] ? {mem[d][i0], mem[d][i1]} : {8'h00, mem[d][i0]};
                end
            end
        end
    end

    logic        armed = 1'b0;
    int          k [2];
    logic        cp [2];
    logic        cwe [2];
    logic        csz [2];
    logic        last [2];
    logic [15:0] caddr [2];
    logic [15:0] cwd [2];
    logic [15:0] eaddr [2];
    logic [15:0] ewd [2];
    logic        esz [2];
    logic [15:0] erd [2][2];
    logic        eg [2][2];
    logic        edn [2][2];
    logic [7:0]  sh [2][256];

    // Transaction model: an access occupies H+1 cycles after the grant edge, completing into a shadow memory
    always @(posedge clk) begin : model
        logic       p;
        logic [7:0] j0, j1;
        for (int d = 0; d < 2; d++) begin
            if (preload) for (int i = 0; i < 256; i++) sh[d][i] = init_byte(i);
            if (sync) for (int i = 0; i < 256; i++) sh[d][i] = mem[d][i];
            eg[d][0] = 1'b0;
            eg[d][1] = 1'b0;
            edn[d][0] = 1'b0;
            edn[d][1] = 1'b0;
            if (!reset) begin
                armed = 1'b1;
                k[d] = 0;
                last[d] = 1'b1;
                cwe[d] = 1'b0;
                eaddr[d] = 16'h0000;
                ewd[d] = 16'h0000;
                esz[d] = 1'b0;
                erd[d][0] = 16'h0000;
                erd[d][1] = 16'h0000;
            end else if (k[d] == 0) begin
                if (v[d][0] || v[d][1]) begin
                    p = (v[d][0] && v[d][1]) ? ((d == 1) ? 1'b0 : !last[d]) : v[d][1];
                    k[d] = 1;
                    eg[d][p] = 1'b1;
                    last[d] = p;
                    cp[d] = p;
                    cwe[d] = w[d][p];
                    csz[d] = s[d][p];
                    caddr[d] = a[d][p];
                    cwd[d] = wd[d][p];
                    eaddr[d] = a[d][p];
                    ewd[d] = wd[d][p];
                    esz[d] = s[d][p];
                end
            end else if (k[d] == H + 1) begin
                k[d] = 0;
                edn[d][cp[d]] = 1'b1;
                j0 = caddr[d][7:0];
                j1 = j0 + 8'd1;
                if (cwe[d] && csz[d]) begin
                    sh[d][j0] = cwd[d][15:8];
                    sh[d][j1] = cwd[d][7:0];
                end else if (cwe[d]) begin
                    sh[d][j0] = cwd[d][7:0];
                end else begin
                    erd[d][cp[d]] = csz[d] ? {sh[d][j0], sh[d][j1]} : {8'h00, sh[d][j0]};
                end
            end else begin
                k[d] = k[d] + 1;
            end
        end
    end

    int vectors = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock step, then every DUT output against the model
    task automatic tick();
        @(negedge clk);
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d busy", d), 32'(bsy[d]), 32'(k[d] != 0));
                chk($sformatf("d%0d mem_we", d), 32'(mwe[d]), 32'(cwe[d] && k[d] >= 1 && k[d] <= H));
                chk($sformatf("d%0d mem_addr", d), 32'(maddr[d]), 32'(eaddr[d]));
                chk($sformatf("d%0d mem_wdata", d), 32'(mwd[d]), 32'(ewd[d]));
                chk($sformatf("d%0d mem_sz", d), 32'(msz[d]), 32'(esz[d]));
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("d%0d r%0d_grant", d, p), 32'(g[d][p]), 32'(eg[d][p]));
                    chk($sformatf("d%0d r%0d_done", d, p), 32'(dn[d][p]), 32'(edn[d][p]));
                    chk($sformatf("d%0d r%0d_rdata", d, p), 32'(rd[d][p]), 32'(erd[d][p]));
                end
            end
        end
    endtask

    task automatic xfer(input int p, input logic [15:0] ad, input logic [15:0] dat,
                        input logic sz, input logic we, input logic chkr, input logic [15:0] expv);
        int gc [2];
        int dc [2];
        for (int d = 0; d < 2; d++) begin
            v[d][p] = 1'b1;
            a[d][p] = ad;
            wd[d][p] = dat;
            s[d][p] = sz;
            w[d][p] = we;
            gc[d] = 0;
            dc[d] = 0;
        end
        for (int n = 1; n <= 12; n++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                if (g[d][p]) begin
                    gc[d] = n;
                    v[d][p] = 1'b0;
                end
                if (dn[d][p] && dc[d] == 0) dc[d] = n;
            end
            if (dc[0] != 0 && dc[1] != 0) break;
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d xfer grant cycle", d), 32'(gc[d]), 32'd1);
            chk($sformatf("d%0d xfer done cycle", d), 32'(dc[d]), 32'd4);
            if (chkr) chk($sformatf("d%0d xfer rdata", d), 32'(rd[d][p]), 32'(expv));
        end
    endtask

    task automatic settle();
        int ok;
        ok = 0;
        for (int d = 0; d < 2; d++) begin
            v[d][0] = 1'b0;
            v[d][1] = 1'b0;
        end
        for (int n = 0; n < 30; n++) begin
            tick();
            if (!bsy[0] && !bsy[1]) begin
                ok = 1;
                break;
            end
        end
        chk("settle to idle", 32'(ok), 32'd1);
    endtask

    int          gn [2];
    int          go [2][4];
    int          gt [2][4];
    int          idx [2];
    int          dcnt [2];
    int          dt [2][3];
    logic [15:0] dd [2][3];
    logic [15:0] exp_b2b [3] = '{16'h1122, 16'h3344, 16'h5566};
    logic [15:0] pre [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                v[d][p] = 1'b0;
                a[d][p] = 16'h0000;
                wd[d][p] = 16'h0000;
                s[d][p] = 1'b0;
                w[d][p] = 1'b0;
            end
        end
        for (int ph = 0; ph < 2; ph++) begin
            phase = 1'(ph);
            preload = 1'b1;
            reset = 1'b0;
            repeat (3) tick();
            preload = 1'b0;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d reset busy", d), 32'(bsy[d]), 32'd0);
                chk($sformatf("d%0d reset mem_we", d), 32'(mwe[d]), 32'd0);
                chk($sformatf("d%0d reset r0_rdata", d), 32'(rd[d][0]), 32'd0);
                chk($sformatf("d%0d reset mem_addr", d), 32'(maddr[d]), 32'd0);
            end
            reset = 1'b1;
            tick();

            xfer(0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1234);
            xfer(1, 16'h0020, 16'h00AB, 1'b0, 1'b1, 1'b0, 16'h0000);
            xfer(1, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00AB);
            xfer(1, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hAB00);
            for (int d = 0; d < 2; d++) chk($sformatf("d%0d r0_rdata kept", d), 32'(rd[d][0]), 32'h1234);

            for (int d = 0; d < 2; d++) begin
                gn[d] = 0;
                for (int p = 0; p < 2; p++) begin
                    v[d][p] = 1'b1;
                    a[d][p] = p == 1 ? 16'h0020 : 16'h0010;
                    s[d][p] = 1'b1;
                    w[d][p] = 1'b0;
                end
            end
            for (int n = 1; n <= 16; n++) begin
                tick();
                for (int d = 0; d < 2; d++) begin
                    for (int p = 0; p < 2; p++) begin
                        if (g[d][p] && gn[d] < 4) begin
                            go[d][gn[d]] = p;
                            gt[d][gn[d]] = n;
                            gn[d]++;
                        end
                    end
                end
            end
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d arb grant count", d), 32'(gn[d]), 32'd4);
                for (int i = 0; i < gn[d]; i++) begin
                    chk($sformatf("d%0d arb port %0d", d, i), 32'(go[d][i]), (d == 0) ? 32'(i % 2) : 32'd0);
                    chk($sformatf("d%0d arb cycle %0d", d, i), 32'(gt[d][i]), 32'(1 + 4 * i));
                end
            end
            settle();

            for (int d = 0; d < 2; d++) begin
                v[d][0] = 1'b1;
                a[d][0] = 16'h0000;
                s[d][0] = 1'b1;
                w[d][0] = 1'b0;
                idx[d] = 0;
                dcnt[d] = 0;
            end
            for (int n = 1; n <= 16; n++) begin
                tick();
                for (int d = 0; d < 2; d++) begin
                    if (g[d][0]) begin
                        idx[d]++;
                        if (idx[d] < 3) a[d][0] = 16'(2 * idx[d]);
                        else v[d][0] = 1'b0;
                    end
                    if (dn[d][0] && dcnt[d] < 3) begin
                        dt[d][dcnt[d]] = n;
                        dd[d][dcnt[d]] = rd[d][0];
                        dcnt[d]++;
                    end
                end
            end
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d b2b done count", d), 32'(dcnt[d]), 32'd3);
                for (int i = 0; i < dcnt[d]; i++) begin
                    chk($sformatf("d%0d b2b cycle %0d", d, i), 32'(dt[d][i]), 32'(4 * (i + 1)));
                    chk($sformatf("d%0d b2b data %0d", d, i), 32'(dd[d][i]), 32'(exp_b2b[i]));
                end
            end
            settle();

            for (int d = 0; d < 2; d++) begin
                pre[d] = {mem[d][8'h30], mem[d][8'h31]};
                v[d][0] = 1'b1;
                a[d][0] = 16'h0030;
                wd[d][0] = 16'hBEEF;
                s[d][0] = 1'b1;
                w[d][0] = 1'b1;
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d rst-mid grant", d), 32'(g[d][0]), 32'd1);
                v[d][0] = 1'b0;
            end
            reset = 1'b0;
            tick();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d rst-mid mem_we", d), 32'(mwe[d]), 32'd0);
                chk($sformatf("d%0d rst-mid busy", d), 32'(bsy[d]), 32'd0);
            end
            reset = 1'b1;
            repeat (4) begin
                tick();
                for (int d = 0; d < 2; d++) chk($sformatf("d%0d rst-mid no done", d), 32'(dn[d][0]), 32'd0);
            end
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d rst-mid atomic", d),
                    32'({mem[d][8'h30], mem[d][8'h31]} == pre[d] || {mem[d][8'h30], mem[d][8'h31]} == 16'hBEEF), 32'd1);
            end
            sync = 1'b1;
            tick();
            sync = 1'b0;
            xfer(0, 16'h0030, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);

            for (int n = 0; n < 400; n++) begin
                tick();
                for (int d = 0; d < 2; d++) begin
                    for (int p = 0; p < 2; p++) begin
                        if (v[d][p] && (g[d][p] || $urandom_range(31) == 0)) begin
                            v[d][p] = 1'b0;
                        end else if (!v[d][p] && $urandom_range(2) == 0) begin
                            v[d][p] = 1'b1;
                            a[d][p] = 16'($urandom_range(63));
                            wd[d][p] = 16'($urandom);
                            s[d][p] = 1'($urandom_range(1));
                            w[d][p] = 1'($urandom_range(1));
                        end
                    end
                end
            end
            settle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/tb_mem_arbiter.md
Name: tb_mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port, synchronous test memory in the test benches.
- Shares the memory between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Holds each command stable long enough to cross one active memory edge; the memory services only every other clk edge, and the arbiter does not know the phase.
- Returns read data with a one-cycle done pulse.

Parameters:
- ADDR_W, 16, address width (matches CPU address bus).
- DATA_W, 16, data width (matches 16-bit data bus).
- MEM_HOLD, 2, cycles each command is driven with write enable; must be >= the memory's service period; legal range 1..15.
- FIXED_PRIORITY, 0; 0 = round-robin between ports, 1 = port 0 always wins ties.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous reset, active-low (0 = reset), sampled on posedge clk.
- rN_valid  in  1  request from port N (N = 0,1); held until rN_grant.
- rN_addr  in  ADDR_W  request byte address.
- rN_wdata  in  DATA_W  write data; 8-bit writes use bits [7:0].
- rN_sz  in  1  access size; 0 = 8-bit, 1 = 16-bit (same encoding as the memory).
- rN_we  in  1  1 = write, 0 = read.
- rN_grant  out  1  one-cycle pulse; the command was latched.
- rN_done  out  1  one-cycle pulse; the access completed and rN_rdata is valid.
- rN_rdata  out  DATA_W  read result; held until the next read completion on that port.
- mem_addr  out  ADDR_W  to memory addr_in.
- mem_wdata  out  DATA_W  to memory write_data_in.
- mem_sz  out  1  to memory data_acc_sz.
- mem_we  out  1  to memory write_data_we.
- mem_rdata  in  DATA_W  from memory read_data_out.
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE.
  - All outputs go to 0: mem_*, rN_grant, rN_done, rN_rdata, busy.
  - last_served = 1, hold counter = 0.
  - An in-flight access is abandoned: no done, and mem_we is 0 from the next cycle.
- FSM states: IDLE, ACCESS, SETTLE. All outputs are registered.
- IDLE:
  - Any rN_valid sampled high -> select winner, latch addr/wdata/sz/we into mem_*, pulse rN_grant next cycle, go to ACCESS, counter = MEM_HOLD-1.
  - Neither valid -> stay; mem_we = 0.
- Arbitration, when both valid:
  - FIXED_PRIORITY=0: grant the port != last_served.
  - FIXED_PRIORITY=1: grant port 0.
  - last_served updates to the winner on every grant.
  - A single valid requester is always granted.
- ACCESS:
  - mem_* held constant; mem_we = latched we.
  - Counter decrements each cycle; at 0 go to SETTLE.
  - Lasts exactly MEM_HOLD cycles.
- SETTLE:
  - One cycle; mem_we = 0; mem_addr/mem_sz held, so a repeated read is harmless.
  - At the ending edge: if the access was a read, capture mem_rdata into the winner's rN_rdata. Pulse the winner's rN_done next cycle. Go to IDLE.
- Writes:
  - done pulses with rN_rdata unchanged.
  - Since mem_we is high for MEM_HOLD consecutive cycles, the write occurs exactly once per access.
- Timing (MEM_HOLD=2), with valid sampled at edge 0:
  - grant high in cycle 1.
  - ACCESS in cycles 1–2, SETTLE in cycle 3.
  - done high in cycle 4, with the state already IDLE.
  - Throughput is MEM_HOLD+2 cycles per access.
- Back-to-back: in the done cycle the arbiter is in IDLE and may sample a new valid, so a done and the next access's latch happen at the same edge.
- Only one access is outstanding at a time; the non-winning valid simply waits, with no queueing.
- A requester dropping valid before grant is legal; nothing is issued for it.
- 8-bit reads: mem_rdata is passed through unmodified (the memory zero-extends).

Test Plan:
- Single read, port 0: preload mem[0x0010]=0x12, mem[0x0011]=0x34; r0 read addr 0x0010, sz=1 -> r0_grant in cycle 1, r0_done in cycle 4, r0_rdata=0x1234, r1_* unchanged.
- 8-bit write then read, port 1: write 0x00AB to 0x0020, sz=0 -> done in cycle 4; then read 0x0020, sz=0 -> r1_rdata=0x00AB; mem[0x0021] unchanged (0x00).
- Round-robin: r0 and r1 both held valid, 4 accesses -> grant order 0,1,0,1, one access per 4 cycles. Repeat with FIXED_PRIORITY=1 -> order 0,0,0,0 while r0 stays valid.
- Back-to-back: r0 valid continuously with reads to 0x0000, 0x0002, 0x0004 -> done pulses in cycles 4, 8, 12 with the preloaded data in order.
- Reset mid-access: assert reset=0 during ACCESS of a 16-bit write of 0xBEEF to 0x0030 -> next cycle mem_we=0, busy=0, no done; mem[0x0030..31] is either unchanged or 0xBEEF, never a partial byte. After release, a read completes normally.
- Memory phase: run each scenario with the memory's internal toggle started in both phases -> identical rdata and done timing.
